mem_port_arbiter: RTL and testbench

- Shares the single-ported data memory between the instruction-fetch (IF) requester and the MEM-stage load/store requester of the pipelined RV32I core.
- Drives the memory's MemRead, MemWrite, addr and data_in inputs, and returns read data through registered response ports.
- Raises per-requester stall signals to the hazard unit.
- Data requests have priority, with a bounded-starvation guarantee for fetch.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter.
// State codes, memory op codes and starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_e;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch waits.
// Ports: clk, rst, if_req, grant_if, grant_d -> cnt, force_if.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic                    grant_if,
  input  logic                    grant_d,
  output logic [STARVE_CNT_W-1:0] cnt,
  output logic                    force_if
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C =
    STARVE_CNT_W'(STARVE_MAX);

  assign force_if = (cnt == MAX_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (grant_if || !if_req) begin
      cnt <= '0;
    end else if (grant_d && cnt != MAX_C) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data memory between fetch and the MEM-stage requester.
// Ports: if_* fetch side, d_* data side, mem_* memory port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic [1:0]        d_read,
  input  logic [1:0]        d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [1:0]        mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_nx;

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic d_req, d_is_wr;
  logic grant_if, grant_d, force_if;

  assign d_req   = (d_read != MEM_NONE) ||
                   (d_write != MEM_NONE);
  assign d_is_wr = (d_write != MEM_NONE);

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .grant_if(grant_if),
    .grant_d (grant_d),
    .cnt     (starve_cnt),
    .force_if(force_if)
  );

  // Both arms are mutually exclusive by construction.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        if_req && (!d_req || force_if):
          grant_if = 1'b1;
        d_req && !(if_req && force_if):
          grant_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = IDLE;
    if (grant_d)
      state_nx = DGRANT;
    else if (grant_if)
      state_nx = IGRANT;
  end

  // A conflicting read+write is issued as a write only.
  always_comb begin
    mem_read  = MEM_NONE;
    mem_write = MEM_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_read  = d_is_wr ? MEM_NONE : d_read;
      mem_write = d_write;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_if) begin
      mem_read  = MEM_WORD;
      mem_addr  = if_addr;
    end
  end

  assign if_stall = if_req & ~grant_if;
  assign d_stall  = d_req & ~grant_d;

  // Last-grant state selects who gets the response pulse;
  // a pulse landing in a reset cycle is suppressed.
  assign if_rvalid = (state == IGRANT) & ~rst;
  assign d_rvalid  = (state == DGRANT) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (grant_if)
        if_rdata <= mem_rdata;
      if (grant_d)
        d_rdata <= d_is_wr ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Includes a small behavioural memory on the mem_* port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        if_stall, if_rvalid;
  logic [31:0] if_rdata;
  logic [1:0]  d_read, d_write;
  logic [5:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_stall, d_rvalid;
  logic [31:0] d_rdata;
  logic [1:0]  mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  logic        init_mem;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(6), .DATA_W(32), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_stall(if_stall), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_stall(d_stall), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'd0;
      mem[0]  <= 32'd17;
      mem[1]  <= 32'd9;
      mem[2]  <= 32'd25;
      mem[6]  <= 32'd77;
      mem[55] <= 32'd56;
    end else if (mem_write != 2'b00) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_gi;
  int dleft, run, maxrun;

  initial begin
    rst = 1'b1; init_mem = 1'b1;
    if_req = 0; if_addr = 0;
    d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    tick(); tick();
    init_mem = 1'b0;
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_state", 32'(dut.state), 0);
    chk("rst_starve", 32'(dut.starve_cnt), 0);
    if_req = 1'b1; #1;
    chk("rst_if_stall", 32'(if_stall), 1);
    chk("rst_mem_read", 32'(mem_read), 0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;

    // Fetch only
    if_req = 1; if_addr = 0; #1;
    chk("f_stall", 32'(if_stall), 0);
    chk("f_mem_read", 32'(mem_read), 1);
    tick();
    if_req = 0;
    chk("f_rvalid", 32'(if_rvalid), 1);
    chk("f_rdata", if_rdata, 17);
    chk("f_d_rvalid", 32'(d_rvalid), 0);
    tick();
    chk("f_pulse", 32'(if_rvalid), 0);
    chk("f_hold", if_rdata, 17);

    // Conflict: data wins, fetch follows
    if_req = 1; if_addr = 1;
    d_read = 1; d_addr = 2; #1;
    chk("c_if_stall", 32'(if_stall), 1);
    chk("c_d_stall", 32'(d_stall), 0);
    chk("c_addr", 32'(mem_addr), 2);
    tick();
    d_read = 0; #1;
    chk("c_d_rvalid", 32'(d_rvalid), 1);
    chk("c_d_rdata", d_rdata, 25);
    chk("c_if_rv0", 32'(if_rvalid), 0);
    chk("c_if_stall2", 32'(if_stall), 0);
    chk("c_addr2", 32'(mem_addr), 1);
    tick();
    if_req = 0;
    chk("c_if_rvalid", 32'(if_rvalid), 1);
    chk("c_if_rdata", if_rdata, 9);
    chk("c_d_rv0", 32'(d_rvalid), 0);
    chk("c_d_hold", d_rdata, 25);

    // Store then load
    d_write = 1; d_addr = 5; d_wdata = 32'hDEADBEEF; #1;
    chk("s_mem_write", 32'(mem_write), 1);
    chk("s_mem_read", 32'(mem_read), 0);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    d_write = 0;
    chk("s_rvalid", 32'(d_rvalid), 1);
    chk("s_rdata", d_rdata, 0);
    chk("s_mem", mem[5], 32'hDEADBEEF);
    d_read = 1; d_addr = 5;
    tick();
    d_read = 0;
    chk("l_rvalid", 32'(d_rvalid), 1);
    chk("l_rdata", d_rdata, 32'hDEADBEEF);

    // Illegal read+write: write wins, no read data
    d_read = 1; d_write = 1; d_addr = 6;
    d_wdata = 32'h1234; #1;
    chk("x_mem_read", 32'(mem_read), 0);
    tick();
    d_read = 0; d_write = 0;
    chk("x_rvalid", 32'(d_rvalid), 1);
    chk("x_rdata", d_rdata, 0);
    chk("x_mem", mem[6], 32'h1234);
    tick();

    // Starvation bound: D D D I D D D I
    exp_gi = 8'b1000_1000;
    dleft = 6; run = 0; maxrun = 0;
    if_req = 1; if_addr = 0; d_addr = 2;
    for (int i = 0; i < 8; i++) begin
      d_read = (dleft > 0) ? 2'd1 : 2'd0;
      #1;
      chk($sformatf("sv_gi%0d", i),
          32'(!if_stall), 32'(exp_gi[i]));
      if (if_stall) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (d_read != 0 && !d_stall) dleft--;
      tick();
    end
    if_req = 0; d_read = 0;
    chk("sv_maxrun", maxrun, 3);
    chk("sv_dleft", dleft, 0);
    tick();

    // Reset mid-transaction
    d_read = 1; d_addr = 55;
    tick();
    d_read = 0; rst = 1; #1;
    chk("r_rv_in_rst", 32'(d_rvalid), 0);
    chk("r_mem_read", 32'(mem_read), 0);
    tick();
    rst = 0;
    chk("r_rvalid", 32'(d_rvalid), 0);
    chk("r_rdata", d_rdata, 0);
    chk("r_state", 32'(dut.state), 0);
    chk("r_starve", 32'(dut.starve_cnt), 0);
    d_read = 1; d_addr = 55;
    tick();
    d_read = 0;
    chk("r_new_rvalid", 32'(d_rvalid), 1);
    chk("r_new_rdata", d_rdata, 56);
    tick();

    // Idle
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("idle%0d", i),
          {24'd0, mem_read, mem_write, if_stall,
           d_stall, if_rvalid, d_rvalid}, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
